// File: rtl/tc1_multi.sv
// tc1_multi -- multi-channel MAX31855 (Pmod TC1) thermocouple reader.
//
// Several TC1 modules share one SCLK/MISO pair; each module has its own
// active-low chip select. SCLK is derived from clk by a counter, so there is
// no gated or generated clock. A read clocks in 14, 16 or 32 bits and then
// splits the captured word into the result registers. An optional auto-scan
// mode reads every channel in turn (32-bit reads) with SCAN_GAP idle cycles
// between transactions.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   SCLK, MISO, CS  shared SPI clock (idle low), shared data in, per-channel selects
//   start, channel  one-shot request and its target channel (sampled in IDLE only)
//   mode            read length: 0 = 14 bit, 1 = 16 bit, 2/3 = 32 bit
//   auto            enable round-robin 32-bit scanning
//   busy            transaction accepted and not yet past the CS-high gap
//   valid, err      one-cycle pulses: results updated / request to a bad channel
//   ch_out          channel of the last completed read
//   temp_termoc     thermocouple temperature, 0.25 C/LSB, two's complement
//   temp_internal   cold-junction temperature, 0.0625 C/LSB, two's complement
//   status, fault   {SCV, SCG, OC} fault bits and the summary fault bit
module tc1_multi #(
  parameter int  CHANNELS = 4,
  parameter int  CLK_DIV  = 10,
  parameter int  SCAN_GAP = 1000,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                SCLK,
  input  logic                MISO,
  output logic [CHANNELS-1:0] CS,
  input  logic                start,
  input  logic [CH_W-1:0]     channel,
  input  logic [1:0]          mode,
  input  logic                auto,
  output logic                busy,
  output logic                valid,
  output logic                err,
  output logic [CH_W-1:0]     ch_out,
  output logic [13:0]         temp_termoc,
  output logic [11:0]         temp_internal,
  output logic [2:0]          status,
  output logic                fault
);

  localparam int CNT_W  = $clog2(2 * CLK_DIV);
  localparam int SCAN_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;

  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_GAP - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);
  // One bit wider than channel so the range test is meaningful for any CHANNELS.
  localparam logic [CH_W:0]     CH_LIMIT  = (CH_W + 1)'(CHANNELS);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP} state_t;
  typedef enum logic [1:0] {LEN_STD, LEN_FLT, LEN_ALL} len_t;

  function automatic len_t len_of(input logic [1:0] m);
    case (m)
      2'd0:    return LEN_STD;
      2'd1:    return LEN_FLT;
      default: return LEN_ALL;
    endcase
  endfunction

  // Index of the final bit of a read (bit counter starts at 0).
  function automatic logic [5:0] last_bit(input len_t l);
    case (l)
      LEN_STD: return 6'd13;
      LEN_FLT: return 6'd15;
      default: return 6'd31;
    endcase
  endfunction

  function automatic logic [CHANNELS-1:0] cs_for(input logic [CH_W-1:0] ch);
    logic [CHANNELS-1:0] r;
    for (int i = 0; i < CHANNELS; i++) r[i] = (ch != CH_W'(i));
    return r;
  endfunction

  state_t              state_q, state_d;
  len_t                len_q, len_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [5:0]          bit_q, bit_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [CH_W-1:0]     scan_q, scan_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [31:0]         sr_q, sr_d;
  logic                sclk_q, sclk_d;
  logic [CHANNELS-1:0] cs_q, cs_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [CH_W-1:0]     ch_out_q, ch_out_d;
  logic [13:0]         termoc_q, termoc_d;
  logic [11:0]         internal_q, internal_d;
  logic [2:0]          status_q, status_d;
  logic                fault_q, fault_d;

  logic                launch;
  logic [CH_W-1:0]     launch_ch;
  len_t                launch_len;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    scan_cnt_d = scan_cnt_q;
    scan_d     = scan_q;
    ch_d       = ch_q;
    sr_d       = sr_q;
    sclk_d     = sclk_q;
    cs_d       = cs_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    ch_out_d   = ch_out_q;
    termoc_d   = termoc_q;
    internal_d = internal_q;
    status_d   = status_q;
    fault_d    = fault_q;
    launch     = 1'b0;
    launch_ch  = channel;
    launch_len = len_of(mode);

    case (state_q)
      S_IDLE: begin
        // An explicit request wins over the scan timer and restarts it.
        if (start) begin
          scan_cnt_d = '0;
          if ({1'b0, channel} >= CH_LIMIT) err_d  = 1'b1;
          else                             launch = 1'b1;
        end else if (auto) begin
          if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            launch     = 1'b1;
            launch_ch  = scan_q;
            launch_len = LEN_ALL;
            scan_d     = (scan_q == CH_LAST) ? '0 : scan_q + 1'b1;
          end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
          end
        end else begin
          scan_cnt_d = '0;
        end

        if (launch) begin
          state_d = S_SETUP;
          ch_d    = launch_ch;
          len_d   = launch_len;
          cnt_d   = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
          cs_d    = cs_for(launch_ch);
        end
      end

      S_SETUP: begin
        if (cnt_q == HALF_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          sclk_d  = 1'b1;
          sr_d    = {sr_q[30:0], MISO};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          sclk_d = 1'b0;
          cnt_d  = cnt_q + 1'b1;
        end else if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (bit_q == last_bit(len_q)) begin
            // Low phase of the final bit is over: release CS and publish.
            state_d  = S_GAP;
            cs_d     = '1;
            valid_d  = 1'b1;
            ch_out_d = ch_q;
            case (len_q)
              LEN_STD: termoc_d = sr_q[13:0];
              LEN_FLT: begin
                termoc_d = sr_q[15:2];
                fault_d  = sr_q[0];
              end
              default: begin
                termoc_d   = sr_q[31:18];
                fault_d    = sr_q[16];
                internal_d = sr_q[15:4];
                status_d   = sr_q[2:0];
              end
            endcase
          end else begin
            // MISO is captured on the edge that raises SCLK; the module
            // changed it on the previous falling edge.
            bit_d  = bit_q + 1'b1;
            sclk_d = 1'b1;
            sr_d   = {sr_q[30:0], MISO};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        // Keeps CS high for the module's minimum deselect time.
        if (cnt_q == FULL_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= LEN_STD;
      cnt_q      <= '0;
      bit_q      <= '0;
      scan_cnt_q <= '0;
      scan_q     <= '0;
      ch_q       <= '0;
      sr_q       <= '0;
      sclk_q     <= 1'b0;
      cs_q       <= '1;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      ch_out_q   <= '0;
      termoc_q   <= '0;
      internal_q <= '0;
      status_q   <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      scan_cnt_q <= scan_cnt_d;
      scan_q     <= scan_d;
      ch_q       <= ch_d;
      sr_q       <= sr_d;
      sclk_q     <= sclk_d;
      cs_q       <= cs_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      ch_out_q   <= ch_out_d;
      termoc_q   <= termoc_d;
      internal_q <= internal_d;
      status_q   <= status_d;
      fault_q    <= fault_d;
    end
  end

  assign SCLK          = sclk_q;
  assign CS            = cs_q;
  assign busy          = busy_q;
  assign valid         = valid_q;
  assign err           = err_q;
  assign ch_out        = ch_out_q;
  assign temp_termoc   = termoc_q;
  assign temp_internal = internal_q;
  assign status        = status_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_tc1_multi.sv
// Testbench for tc1_multi: directed reads against a MAX31855 model per
// channel. A second, 5-channel instance exercises the out-of-range request
// path, which a 4-channel instance cannot express with a 2-bit channel.
module tb_tc1_multi;

  localparam int CHANNELS = 4;
  localparam int CLK_DIV  = 4;
  localparam int SCAN_GAP = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance
  logic        sclk, miso, start, auto, busy, valid, err, fault;
  logic [3:0]  cs;
  logic [1:0]  channel, mode, ch_out;
  logic [13:0] termoc;
  logic [11:0] internal;
  logic [2:0]  status;

  tc1_multi #(.CHANNELS(CHANNELS), .CLK_DIV(CLK_DIV), .SCAN_GAP(SCAN_GAP)) dut (
    .clk(clk), .rst(rst), .SCLK(sclk), .MISO(miso), .CS(cs),
    .start(start), .channel(channel), .mode(mode), .auto(auto),
    .busy(busy), .valid(valid), .err(err), .ch_out(ch_out),
    .temp_termoc(termoc), .temp_internal(internal), .status(status), .fault(fault)
  );

  // Five-channel instance; its MISO is held low
  logic        sclk5, start5, busy5, valid5, err5, fault5;
  logic        miso5 = 1'b0;
  logic        auto5 = 1'b0;
  logic [4:0]  cs5;
  logic [2:0]  channel5, ch_out5, status5;
  logic [1:0]  mode5;
  logic [13:0] termoc5;
  logic [11:0] internal5;

  tc1_multi #(.CHANNELS(5), .CLK_DIV(CLK_DIV), .SCAN_GAP(SCAN_GAP)) dut5 (
    .clk(clk), .rst(rst), .SCLK(sclk5), .MISO(miso5), .CS(cs5),
    .start(start5), .channel(channel5), .mode(mode5), .auto(auto5),
    .busy(busy5), .valid(valid5), .err(err5), .ch_out(ch_out5),
    .temp_termoc(termoc5), .temp_internal(internal5), .status(status5), .fault(fault5)
  );

  // MAX31855 model and bus monitor, evaluated on the falling clk edge.
  // A selected module drives the MSB after CS falls and advances one bit on
  // each SCLK falling edge.
  logic [31:0] words [CHANNELS];
  logic [31:0] m_sr      = '0;
  logic        m_act     = 1'b0;
  logic        sclk_prev = 1'b0;
  logic        busy_prev = 1'b0;
  logic [3:0]  cs_seen   = 4'hF;
  int cyc = 0, rise_cnt = 0, cs_low_cnt = 0, valid_cnt = 0, valid5_cnt = 0;
  int busy_fall_cyc = 0, cs_fall_cyc = 0;

  function automatic int sel_idx(input logic [3:0] c);
    int r = 0;
    for (int i = 0; i < 4; i++) if (!c[i]) r = i;
    return r;
  endfunction

  assign miso = m_act ? m_sr[31] : 1'b0;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    sclk_prev <= sclk;
    busy_prev <= busy;
    if (sclk && !sclk_prev) rise_cnt <= rise_cnt + 1;
    if (cs != 4'hF) begin
      cs_low_cnt <= cs_low_cnt + 1;
      cs_seen    <= cs;
    end
    if (valid)  valid_cnt  <= valid_cnt + 1;
    if (valid5) valid5_cnt <= valid5_cnt + 1;
    if (busy_prev && !busy) busy_fall_cyc <= cyc;
    if (&cs) begin
      m_act <= 1'b0;
    end else if (!m_act) begin
      m_act       <= 1'b1;
      m_sr        <= words[sel_idx(cs)];
      cs_fall_cyc <= cyc;
    end else if (sclk_prev && !sclk) begin
      m_sr <= {m_sr[30:0], 1'b0};
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] ch, input logic [1:0] md);
    @(negedge clk);
    start   = 1'b1;
    channel = ch;
    mode    = md;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input bit on5, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = on5 ? valid5 : valid;
    end
    #1;
    check({tag, " valid"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    #1;
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  // Expected fields for the auto-scan words (hand-decoded)
  logic [31:0] scan_words [4] = '{32'h0190_1900, 32'hFFFC_FFF0, 32'h0001_0005, 32'h1234_5672};
  logic [13:0] exp_termoc [4] = '{14'h064, 14'h3FFF, 14'h000, 14'h48D};
  logic [11:0] exp_int    [4] = '{12'h190, 12'hFFF, 12'h000, 12'h567};
  logic [2:0]  exp_stat   [4] = '{3'd0, 3'd0, 3'd5, 3'd2};
  logic        exp_fault  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int r0, c0, v0, k;
    start = 1'b0; channel = '0; mode = '0; auto = 1'b0;
    start5 = 1'b0; channel5 = '0; mode5 = '0;
    for (int i = 0; i < CHANNELS; i++) words[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst CS", 32'(cs), 32'hF);
    check("rst SCLK", 32'(sclk), 32'd0);
    check("rst busy/valid/err", {busy, valid, err}, 32'd0);
    check("rst data", {ch_out, termoc, internal, status, fault}, 32'd0);
    check("rst CS5", 32'(cs5), 32'h1F);
    rst = 1'b0;
    r0 = rise_cnt;
    repeat (100) @(negedge clk);
    #1;
    check("idle no SCLK", 32'(rise_cnt - r0), 32'd0);
    check("idle CS", 32'(cs), 32'hF);

    // ALL read, channel 2
    words[2] = 32'h0190_1900;
    r0 = rise_cnt; c0 = cs_low_cnt; v0 = valid_cnt;
    issue(2'd2, 2'd2);
    check("all accept CS", 32'(cs), 32'hB);
    check("all accept busy", 32'(busy), 32'd1);
    wait_valid("all", 1'b0, 400);
    check("all CS high at valid", 32'(cs), 32'hF);
    check("all CS seen", 32'(cs_seen), 32'hB);
    check("all CS low cycles", 32'(cs_low_cnt - c0), 32'd260);
    check("all SCLK rises", 32'(rise_cnt - r0), 32'd32);
    check("all ch_out", 32'(ch_out), 32'd2);
    check("all termoc", 32'(termoc), 32'h064);
    check("all internal", 32'(internal), 32'h190);
    check("all status/fault", {status, fault}, 32'd0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 40);
    #1;
    check("all busy fall delay", 32'(k), 32'd8);
    check("all one valid", 32'(valid_cnt - v0), 32'd1);

    // FLT read, channel 0
    words[0] = 32'hFFF1_ABCD;
    issue(2'd0, 2'd1);
    wait_valid("flt", 1'b0, 400);
    check("flt ch_out", 32'(ch_out), 32'd0);
    check("flt termoc", 32'(termoc), 32'h3FFC);
    check("flt fault", 32'(fault), 32'd1);
    check("flt internal held", 32'(internal), 32'h190);
    check("flt status held", 32'(status), 32'd0);
    wait_idle("flt");

    // STD read, channel 0: top 14 bits are 14'h0050
    words[0] = 32'h0140_3FFF;
    r0 = rise_cnt; c0 = cs_low_cnt;
    issue(2'd0, 2'd0);
    wait_valid("std", 1'b0, 400);
    check("std CS low cycles", 32'(cs_low_cnt - c0), 32'd116);
    check("std SCLK rises", 32'(rise_cnt - r0), 32'd14);
    check("std termoc", 32'(termoc), 32'h0050);
    check("std fault held", 32'(fault), 32'd1);
    check("std internal held", 32'(internal), 32'h190);
    wait_idle("std");

    // Out-of-range channel on the 5-channel instance
    @(negedge clk);
    start5 = 1'b1; channel5 = 3'd5; mode5 = 2'd2;
    @(negedge clk);
    start5 = 1'b0;
    check("inv err pulse", 32'(err5), 32'd1);
    check("inv CS", 32'(cs5), 32'h1F);
    check("inv busy", 32'(busy5), 32'd0);
    @(negedge clk);
    check("inv err one cycle", 32'(err5), 32'd0);
    repeat (50) @(negedge clk);
    #1;
    check("inv no valid", 32'(valid5_cnt), 32'd0);
    check("inv CS after", 32'(cs5), 32'h1F);

    // Highest legal channel on the same instance
    @(negedge clk);
    start5 = 1'b1; channel5 = 3'd4; mode5 = 2'd0;
    @(negedge clk);
    start5 = 1'b0;
    check("ch4 accept CS", 32'(cs5), 32'h0F);
    check("ch4 no err", 32'(err5), 32'd0);
    wait_valid("ch4", 1'b1, 400);
    check("ch4 ch_out", 32'(ch_out5), 32'd4);

    // start while busy is ignored
    words[1] = 32'hFFFC_FFF0;
    v0 = valid_cnt;
    issue(2'd1, 2'd2);
    repeat (100) @(negedge clk);
    start = 1'b1; channel = 2'd3; mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    wait_valid("busy-start", 1'b0, 400);
    check("busy-start ch_out", 32'(ch_out), 32'd1);
    check("busy-start termoc", 32'(termoc), 32'h3FFF);
    check("busy-start internal", 32'(internal), 32'hFFF);
    repeat (400) @(negedge clk);
    #1;
    check("busy-start one valid", 32'(valid_cnt - v0), 32'd1);
    check("busy-start CS idle", 32'(cs), 32'hF);

    // Auto scan: channels 0,1,2,3,0
    for (int i = 0; i < CHANNELS; i++) words[i] = scan_words[i];
    @(negedge clk);
    auto = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_valid($sformatf("scan%0d", n), 1'b0, 1000);
      check($sformatf("scan%0d ch_out", n), 32'(ch_out), 32'(n % 4));
      check($sformatf("scan%0d termoc", n), 32'(termoc), 32'(exp_termoc[n % 4]));
      check($sformatf("scan%0d internal", n), 32'(internal), 32'(exp_int[n % 4]));
      check($sformatf("scan%0d status/fault", n), {status, fault},
            {exp_stat[n % 4], exp_fault[n % 4]});
      if (n > 0)
        check($sformatf("scan%0d gap", n), 32'(cs_fall_cyc - busy_fall_cyc), 32'd50);
    end

    // Reset in the middle of the next scan read
    k = 0;
    while (!sclk && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("mid-shift reached", 32'(sclk), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid rst CS", 32'(cs), 32'hF);
    check("mid rst SCLK", 32'(sclk), 32'd0);
    check("mid rst busy/valid/err", {busy, valid, err}, 32'd0);
    check("mid rst data", {ch_out, termoc, internal, status, fault}, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    wait_valid("restart", 1'b0, 1000);
    check("restart ch_out", 32'(ch_out), 32'd0);
    check("restart termoc", 32'(termoc), 32'h064);

    // Drop auto during the next read: it completes, nothing follows
    k = 0;
    while (cs == 4'hF && k < 200) begin
      @(negedge clk);
      k++;
    end
    auto = 1'b0;
    v0 = valid_cnt;
    wait_valid("auto-off", 1'b0, 400);
    check("auto-off ch_out", 32'(ch_out), 32'd1);
    repeat (300) @(negedge clk);
    #1;
    check("auto-off no relaunch", 32'(valid_cnt - v0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
